// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter
//
// Shares the single request port of the unified SDRAM cache between an
// instruction-fetch requester (read-only) and a data requester (read/write).
// The granted request is captured into registers that drive the cache, so the
// address and byte enables stay stable for the whole access. After each grant
// the cache enable is held low for SettleCycles cycles to cover the registered
// tag/column BRAM read latency. The served port receives its read data and a
// one-cycle done pulse.
//
// Parameters:
//   SettleCycles  cycles with c_enable low after a new address (1..7)
//   DataPriority  0 = round-robin on a tie, 1 = data port always wins a tie
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req/i_addr               instruction read request (level) and byte address
//   i_rdata/i_done             instruction read data, one-cycle completion pulse
//   d_req/d_addr/d_wdata       data request (level), byte address, write data
//   d_wstrb                    byte write enables, 0 = read
//   d_rdata/d_done             data read data (0 after a write), completion pulse
//   c_enable/c_address         cache enable and address
//   c_data_in/c_write_enable   cache write data and byte enables
//   c_data_out                 cache read data
//   c_data_out_ready           cache read hit (not needed: completion is !c_busy)
//   c_busy                     cache miss/fill in progress
//   grant_d                    1 = current or last grant is the data port

module cache_port_arbiter #(
    parameter int unsigned SettleCycles = 1,
    parameter int unsigned DataPriority = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        c_enable,
    output logic [31:0] c_address,
    output logic [31:0] c_data_in,
    output logic [3:0]  c_write_enable,
    input  logic [31:0] c_data_out,
    input  logic        c_data_out_ready,
    input  logic        c_busy,
    output logic        grant_d
);

    typedef enum logic [1:0] {StIdle, StSettle, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_data_q, last_data_d;  // last grant went to the data port
    logic        grant_d_q, grant_d_d;
    logic        en_q, en_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic        pick_data;

    // Hit/miss is fully signalled by c_busy, so the ready flag carries no extra information.
    logic unused_ready;
    assign unused_ready = c_data_out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_data_d = last_data_q;
        grant_d_d   = grant_d_q;
        en_d        = en_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        pick_data   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    if (i_req && d_req) begin
                        pick_data = (DataPriority != 0) ? 1'b1 : !last_data_q;
                    end else begin
                        pick_data = d_req;
                    end
                    addr_d      = pick_data ? d_addr  : i_addr;
                    wdata_d     = pick_data ? d_wdata : 32'h0;
                    wstrb_d     = pick_data ? d_wstrb : 4'h0;
                    last_data_d = pick_data;
                    grant_d_d   = pick_data;
                    cnt_d       = 3'(SettleCycles);
                    state_d     = StSettle;
                end
            end
            StSettle: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    en_d    = 1'b1;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (!c_busy) begin
                    // Dropping the enables here makes a write land exactly once.
                    en_d    = 1'b0;
                    wstrb_d = 4'h0;
                    if (grant_d_q) begin
                        d_rdata_d = (wstrb_q != 4'h0) ? 32'h0 : c_data_out;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = c_data_out;
                        i_done_d  = 1'b1;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            last_data_q <= 1'b1;
            grant_d_q   <= 1'b0;
            en_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            i_rdata_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_data_q <= last_data_d;
            grant_d_q   <= grant_d_d;
            en_q        <= en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
        end
    end

    assign c_enable       = en_q;
    assign c_address      = addr_q;
    assign c_data_in      = wdata_q;
    assign c_write_enable = wstrb_q;
    assign i_rdata        = i_rdata_q;
    assign d_rdata        = d_rdata_q;
    assign i_done         = i_done_q;
    assign d_done         = d_done_q;
    assign grant_d        = grant_d_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter. Instance dut0 uses default parameters and talks
// to a behavioural cache with programmable busy time; instance dut1 uses
// SettleCycles=3, DataPriority=1 with an always-hit cache.
`timescale 1ns/1ps
module tb_cache_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // dut0 signals
    logic        i_req, i_done, d_req, d_done, c_enable, c_data_out_ready, c_busy, grant_d;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, c_address, c_data_in, c_data_out;
    logic [3:0]  d_wstrb, c_write_enable;

    cache_port_arbiter dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_done(d_done),
        .c_enable(c_enable), .c_address(c_address), .c_data_in(c_data_in),
        .c_write_enable(c_write_enable), .c_data_out(c_data_out),
        .c_data_out_ready(c_data_out_ready), .c_busy(c_busy), .grant_d(grant_d)
    );

    // dut1 signals
    logic        i1_req, i1_done, d1_req, d1_done, c1_enable, grant1_d;
    logic [31:0] i1_addr, i1_rdata, d1_addr, d1_wdata, d1_rdata, c1_address, c1_data_in;
    logic [31:0] c1_data_out;
    logic [3:0]  d1_wstrb, c1_write_enable;

    assign c1_data_out = c1_address ^ 32'hC0DE_F00D;

    cache_port_arbiter #(.SettleCycles(3), .DataPriority(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i1_req), .i_addr(i1_addr), .i_rdata(i1_rdata), .i_done(i1_done),
        .d_req(d1_req), .d_addr(d1_addr), .d_wdata(d1_wdata), .d_wstrb(d1_wstrb),
        .d_rdata(d1_rdata), .d_done(d1_done),
        .c_enable(c1_enable), .c_address(c1_address), .c_data_in(c1_data_in),
        .c_write_enable(c1_write_enable), .c_data_out(c1_data_out),
        .c_data_out_ready(1'b1), .c_busy(1'b0), .grant_d(grant1_d)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string detail);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s", name, detail);
    endtask

    // ---------------- memory models ----------------
    logic [31:0] cmem [logic [31:0]];  // contents seen by the cache
    logic [31:0] rmem [logic [31:0]];  // reference memory, updated at issue time

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    function automatic logic [31:0] cache_rd(input logic [31:0] a);
        if (cmem.exists(a)) return cmem[a];
        return init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (rmem.exists(a)) return rmem[a];
        return init_val(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // ---------------- cache model for dut0 ----------------
    bit in_acc = 0;
    int busy_left = 0;
    int fixed_busy = -1;  // -1 = random busy time per access
    int we_cycles = 0;
    int cache_writes = 0;
    int n_writes = 0;

    initial begin
        c_busy = 1'b0;
        c_data_out = 32'h0;
        c_data_out_ready = 1'b0;
        forever begin
            @(negedge clk);
            c_data_out = cache_rd(c_address);
            if (!rst_n || !c_enable) begin
                in_acc = 0;
                busy_left = 0;
                c_busy = 1'b0;
            end else if (!in_acc) begin
                in_acc = 1;
                busy_left = (fixed_busy >= 0) ? fixed_busy : int'($urandom_range(0, 4));
                c_busy = (busy_left > 0);
            end else begin
                if (busy_left > 0) busy_left--;
                c_busy = (busy_left > 0);
            end
            c_data_out_ready = c_enable && !c_busy;
            if (c_enable && c_write_enable != 4'h0) we_cycles++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && c_enable && !c_busy && c_write_enable != 4'h0) begin
                cmem[c_address] = merge(cache_rd(c_address), c_data_in, c_write_enable);
                cache_writes++;
            end
        end
    end

    // ---------------- scoreboard monitor for dut0 ----------------
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    byte         done_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (i_done || d_done) begin
                    check("done_onehot", 32'(i_done & d_done), 32'h0);
                    check("enables_off_in_done", {27'h0, c_enable, c_write_enable}, 32'h0);
                end
                if (i_done) begin
                    done_log.push_back("I");
                    check("i_grant_d", 32'(grant_d), 32'h0);
                    if (iq.size() == 0) fail("i_unexpected_done", "got i_done=1, required no pulse");
                    else check("i_rdata", i_rdata, iq.pop_front());
                end
                if (d_done) begin
                    done_log.push_back("D");
                    check("d_grant_d", 32'(grant_d), 32'h1);
                    if (dq.size() == 0) fail("d_unexpected_done", "got d_done=1, required no pulse");
                    else check("d_rdata", d_rdata, dq.pop_front());
                end
            end
        end
    end

    // ---------------- requester drivers (called at a negedge) ----------------
    task automatic i_read(input logic [31:0] a, output int lat);
        int unsigned start;
        bit got;
        got = 0;
        i_addr = a;
        iq.push_back(ref_rd(a));
        i_req = 1'b1;
        start = cyc;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            got = i_done;
        end
        i_req = 1'b0;
        lat = got ? int'(cyc - start) : -1;
        if (!got) fail("i_timeout", $sformatf("got no i_done for %h, required a pulse", a));
    endtask

    task automatic d_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                            output int lat);
        int unsigned start;
        bit got;
        got = 0;
        d_addr = a;
        d_wdata = wd;
        d_wstrb = st;
        if (st != 4'h0) begin
            rmem[a] = merge(ref_rd(a), wd, st);
            dq.push_back(32'h0);
            n_writes++;
        end else begin
            dq.push_back(ref_rd(a));
        end
        d_req = 1'b1;
        start = cyc;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            got = d_done;
        end
        d_req = 1'b0;
        lat = got ? int'(cyc - start) : -1;
        if (!got) fail("d_timeout", $sformatf("got no d_done for %h, required a pulse", a));
    endtask

    task automatic i_random(input int n);
        int lat;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            i_read(32'($urandom_range(0, 255)) << 2, lat);
        end
    endtask

    task automatic d_random(input int n);
        int lat;
        logic [3:0] st;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            st = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            d_access(32'h1000_0000 + (32'($urandom_range(0, 15)) << 2), $urandom, st, lat);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int unsigned start;
        int low, n_i, n_d, wait_c;
        bit seen, got;
        logic [31:0] seq;

        rst_n = 1'b0;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
        i1_req = 1'b0; i1_addr = 32'h0;
        d1_req = 1'b0; d1_addr = 32'h0; d1_wdata = 32'h0; d1_wstrb = 4'h0;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_c_enable", 32'(c_enable), 32'h0);
        check("rst_c_address", c_address, 32'h0);
        check("rst_c_data_in", c_data_in, 32'h0);
        check("rst_c_we", 32'(c_write_enable), 32'h0);
        check("rst_dones", {30'h0, i_done, d_done}, 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_grant_d", 32'(grant_d), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // instruction read hit
        fixed_busy = 0;
        cmem[32'h40] = 32'hDEAD_BEEF;
        rmem[32'h40] = 32'hDEAD_BEEF;
        i_read(32'h0000_0040, lat);
        check("ihit_latency", 32'(lat), 32'd3);
        repeat (3) @(negedge clk);
        check("addr_hold_after_done", c_address, 32'h0000_0040);

        // data write with 20 busy cycles
        fixed_busy = 20;
        we_cycles = 0;
        d_access(32'h0000_0100, 32'h1234_5678, 4'b0011, lat);
        check("wr_latency", 32'(lat), 32'd23);
        @(negedge clk);
        check("wr_we_cycles", 32'(we_cycles), 32'd21);
        check("wr_cache_word", cache_rd(32'h100),
              (init_val(32'h100) & 32'hFFFF_0000) | 32'h0000_5678);

        // round-robin with both requests held
        fixed_busy = 0;
        do_reset();
        done_log.delete();
        i_addr = 32'h40;
        d_addr = 32'h1000_0010; d_wstrb = 4'h0; d_wdata = 32'h0;
        repeat (2) begin
            iq.push_back(ref_rd(32'h40));
            dq.push_back(ref_rd(32'h1000_0010));
        end
        i_req = 1'b1;
        d_req = 1'b1;
        repeat (15) @(negedge clk);
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check("rr_done_count", 32'(done_log.size()), 32'd4);
        seq = 32'h0;
        foreach (done_log[k]) seq = {seq[23:0], done_log[k]};
        check("rr_order", seq, {"I", "D", "I", "D"});

        // random traffic on both ports
        fixed_busy = -1;
        repeat (2) @(negedge clk);
        fork
            i_random(40);
            d_random(40);
        join
        repeat (4) @(negedge clk);
        check("i_queue_drained", 32'(iq.size()), 32'h0);
        check("d_queue_drained", 32'(dq.size()), 32'h0);
        check("writes_applied_once", 32'(cache_writes), 32'(n_writes));

        // reset in the middle of a missing access
        fixed_busy = 10;
        d_addr = 32'h1000_0020; d_wstrb = 4'h0;
        d_req = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_rst_in_access", 32'(c_enable), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_c_enable", 32'(c_enable), 32'h0);
        check("rst_mid_dones", {30'h0, i_done, d_done}, 32'h0);
        d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fixed_busy = 0;
        i_read(32'h0000_0040, lat);
        check("post_rst_latency", 32'(lat), 32'd3);

        // SettleCycles=3 latency and enable-low window (dut1)
        @(negedge clk);
        i1_addr = 32'h0000_0080;
        i1_req = 1'b1;
        start = cyc;
        low = 0; seen = 0; got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (c1_enable) seen = 1;
            if (!seen && !c1_enable && c1_address == 32'h80) low++;
            got = i1_done;
        end
        i1_req = 1'b0;
        check("s3_latency", cyc - start, 32'd5);
        check("s3_enable_low", 32'(low), 32'd3);
        check("s3_rdata", i1_rdata, 32'h0000_0080 ^ 32'hC0DE_F00D);

        // DataPriority=1: data keeps winning while held (dut1)
        @(negedge clk);
        d1_addr = 32'h0000_0200;
        i1_req = 1'b1;
        d1_req = 1'b1;
        n_i = 0; n_d = 0;
        repeat (17) begin
            @(negedge clk);
            if (i1_done) n_i++;
            if (d1_done) n_d++;
        end
        d1_req = 1'b0;
        check("pri_i_starved", 32'(n_i), 32'd0);
        check("pri_d_dones", 32'(n_d), 32'd3);
        check("pri_d_rdata", d1_rdata, 32'h0000_0200 ^ 32'hC0DE_F00D);
        wait_c = 0; got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            wait_c++;
            got = i1_done;
        end
        i1_req = 1'b0;
        check("pri_i_after_drop", 32'(wait_c), 32'd6);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single request port of the unified SDRAM cache between an instruction-fetch requester (read-only) and a data requester (read/write).
- Captures the granted request into registers and drives the cache from them, so the cache address and byte enables stay stable until the access completes.
- Inserts settle cycles after each grant to cover the registered tag/column BRAM read latency.
- Returns read data and a one-cycle done pulse to the requester that was served.

Parameters:
- SettleCycles, 1, cycles with c_enable low after a new address is driven (1..7).
- DataPriority, 0; 0 = round-robin between ports, 1 = data port always wins a simultaneous request.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- i_req  in  1  instruction read request, level; held until i_done
- i_addr  in  32  instruction byte address
- i_rdata  out  32  read data, valid while i_done=1
- i_done  out  1  one-cycle completion pulse
- d_req  in  1  data request, level; held until d_done
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_wstrb  in  4  byte write enables; 0 = read
- d_rdata  out  32  read data, valid while d_done=1; 0 after a write
- d_done  out  1  one-cycle completion pulse
- c_enable  out  1  cache enable
- c_address  out  32  cache address
- c_data_in  out  32  cache write data
- c_write_enable  out  4  cache byte enables
- c_data_out  in  32  cache read data
- c_data_out_ready  in  1  cache read hit
- c_busy  in  1  cache miss/fill in progress
- grant_d  out  1  1 = current or last grant is the data port

Behaviour:
- One clock (clk); rst_n is asynchronous, active-low.
- Reset state:
  - FSM in Idle.
  - c_enable=0, c_address=0, c_data_in=0, c_write_enable=0.
  - i_done=d_done=0, i_rdata=d_rdata=0.
  - last-grant register = data, so the instruction port wins the first tie; grant_d=0.
- Reset mid-access aborts immediately and returns to the reset values. The cache shares rst_n, so it aborts too.

FSM states: Idle, Settle, Access, Done.
- Idle:
  - Arbitration is evaluated only in Idle.
  - If neither request is high, stay in Idle.
  - If exactly one is high, grant it.
  - If both are high: DataPriority=1 grants data; DataPriority=0 grants the port not granted last.
  - On a grant, register the address, wdata and wstrb (instruction port: wstrb=0, wdata=0) into c_address/c_data_in/c_write_enable.
  - Update last-grant and grant_d, load settle counter = SettleCycles, go to Settle.
- Settle:
  - c_enable=0; decrement the counter.
  - When the counter reaches 1, set c_enable=1 at the next edge and go to Access.
- Access:
  - c_enable=1 and the captured request are held constant.
  - Completion cycle = c_busy==0 in Access.
  - Stay in Access while c_busy=1, with no timeout; a miss with dirty eviction takes tens of cycles.
  - At the completion edge:
    - Capture c_data_out into the granted port's rdata (0 for a write).
    - Drive c_enable=0 and c_write_enable=0, so a write is applied exactly once.
    - Go to Done.
- Done:
  - Exactly one of i_done/d_done=1 for one cycle, with rdata valid. The rdata register holds its value afterwards.
  - Requests are not sampled. A requester still holding req in the cycle after its done is treated as a new request.
  - Next state is Idle.
- Latency on a cache hit with SettleCycles=1:
  - req high in Idle at cycle N; Settle at N+1; Access at N+2 (completes); done at N+3.
  - Back-to-back throughput is one access per 4 cycles.
- A miss adds the cache's busy duration to the Access stay.
- Requester rules:
  - Changing addr/wdata/wstrb while req is high and before done is illegal. It has no effect because the values were captured at grant.
  - Dropping req before done does not cancel the access; done still pulses.
- c_address is not cleared after done. It holds the last address until the next grant, keeping the cache lookup stable.

Test Plan:
- Instruction read hit at 0x0000_0040, cache returns 0xDEAD_BEEF with busy=0 -> i_done=1 exactly at cycle N+3, i_rdata=0xDEAD_BEEF, d_done stays 0.
- Data write 0x0000_0100, wdata 0x1234_5678, wstrb 4'b0011, busy high 20 cycles -> c_write_enable=4'b0011 for 21 cycles in Access, 0 after, d_done one pulse, d_rdata=0.
- i_req and d_req both held continuously, DataPriority=0 -> grants alternate I, D, I, D; four dones in 16 cycles; first grant I.
- Same as above with DataPriority=1 -> only d_done pulses while d_req is held; i_done only after d_req drops.
- SettleCycles=3 -> c_enable low for 3 cycles after the address changes; hit done at cycle N+5.
- rst_n low for 1 cycle during an Access with busy=1 -> c_enable=0 and both done=0 immediately; next request is granted normally from Idle.
